// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter that zero-sweeps the register file after reset or clear.
// Latency: a grant writes one cycle after the handshake. Backpressure: only one ready per cycle, none during the sweep.
module regfile_write_arbiter #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addressIn,
    output logic [DATA_W-1:0] rf_regIn,
    output logic              init_done
);

    // One count past the last register marks the idle cycle before RUN.
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  sweep_cnt, sweep_cnt_nxt;
    logic              last_grant, last_grant_nxt;
    logic              grant0, grant1;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state        <= INIT;
            sweep_cnt    <= '0;
            last_grant   <= 1'b1;
            rf_we        <= 1'b0;
            rf_addressIn <= '0;
            rf_regIn     <= '0;
        end else begin
            state        <= state_nxt;
            sweep_cnt    <= sweep_cnt_nxt;
            last_grant   <= last_grant_nxt;
            rf_we        <= we_nxt;
            rf_addressIn <= addr_nxt;
            rf_regIn     <= data_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sweep_cnt_nxt  = sweep_cnt;
        last_grant_nxt = last_grant;
        grant0         = 1'b0;
        grant1         = 1'b0;
        we_nxt         = 1'b0;
        addr_nxt       = rf_addressIn;
        data_nxt       = rf_regIn;

        case (state)
            INIT: begin
                if (sweep_cnt == CNT_W'(NUM_REGS)) begin
                    state_nxt = RUN;
                end else begin
                    we_nxt        = 1'b1;
                    addr_nxt      = ADDR_W'(sweep_cnt);
                    data_nxt      = '0;
                    sweep_cnt_nxt = sweep_cnt + 1'b1;
                end
            end
            RUN: begin
                if (clear) begin
                    state_nxt     = INIT;
                    sweep_cnt_nxt = '0;
                end else begin
                    // On a tie the requester that did not win last time goes first.
                    grant0 = req0_valid && (!req1_valid || last_grant);
                    grant1 = req1_valid && (!req0_valid || !last_grant);
                    if (grant0) begin
                        we_nxt         = 1'b1;
                        addr_nxt       = req0_addr;
                        data_nxt       = req0_data;
                        last_grant_nxt = 1'b0;
                    end else if (grant1) begin
                        we_nxt         = 1'b1;
                        addr_nxt       = req1_addr;
                        data_nxt       = req1_data;
                        last_grant_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt     = INIT;
                sweep_cnt_nxt = '0;
            end
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign init_done  = (state == RUN);

endmodule
